// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - data-memory arbiter between the MEM stage and a loader/debug port with a starvation guard
module dmem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRd_MEM,
    input  logic        MemWr_MEM,
    input  logic [5:0]  Addr_MEM,
    input  logic [31:0] Din_MEM,
    output logic [31:0] Dout_MEM,
    output logic        Stall_MEM,
    input  logic        ld_valid,
    input  logic        ld_we,
    input  logic [5:0]  ld_addr,
    input  logic [31:0] ld_wdata,
    output logic        ld_ready,
    output logic        ld_rvalid,
    output logic [31:0] ld_rdata,
    output logic        MemRd,
    output logic        MemWr_final,
    output logic [5:0]  Address,
    output logic [31:0] Data_in,
    input  logic [31:0] Data_out
);

    localparam logic ST_NORMAL = 1'b0;
    localparam logic ST_FORCE  = 1'b1;
    localparam logic [4:0] LIMIT = 5'(STARVE_LIMIT);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("dmem_arbiter: STARVE_LIMIT must be 1..15");
    end

    logic        state_q, state_d;
    logic [3:0]  starve_q, starve_d;
    logic        ld_rvalid_q, ld_rvalid_d;
    logic [31:0] ld_rdata_q, ld_rdata_d;

    logic        pipe_req;
    logic        pipe_own;
    logic        ld_own;
    logic [4:0]  starve_inc;

    assign pipe_req   = MemRd_MEM | MemWr_MEM;
    assign starve_inc = {1'b0, starve_q} + 5'd1;

    // Ownership: pipeline has priority except in the single FORCE cycle.
    always_comb begin
        pipe_own = 1'b0;
        ld_own   = 1'b0;
        if (!reset) begin
            if (state_q == ST_FORCE) begin
                ld_own   = ld_valid;
                pipe_own = !ld_valid && pipe_req;
            end else begin
                pipe_own = pipe_req;
                ld_own   = !pipe_req && ld_valid;
            end
        end
    end

    assign ld_ready  = ld_own;
    assign Stall_MEM = !reset && (state_q == ST_FORCE) && ld_valid && pipe_req;

    always_comb begin
        MemRd       = 1'b0;
        MemWr_final = 1'b0;
        Address     = 6'd0;
        Data_in     = 32'd0;
        Dout_MEM    = 32'd0;
        if (pipe_own) begin
            MemRd       = MemRd_MEM;
            MemWr_final = MemWr_MEM;
            Address     = Addr_MEM;
            Data_in     = Din_MEM;
            Dout_MEM    = Data_out;
        end else if (ld_own) begin
            MemRd       = !ld_we;
            MemWr_final = ld_we;
            Address     = ld_addr;
            Data_in     = ld_wdata;
        end
    end

    // FORCE lasts exactly one cycle; the counter only runs while the loader is being denied.
    always_comb begin
        state_d  = ST_NORMAL;
        starve_d = 4'd0;
        if (state_q == ST_NORMAL && ld_valid && pipe_req) begin
            if (starve_inc == LIMIT) begin
                state_d = ST_FORCE;
            end else begin
                starve_d = starve_inc[3:0];
            end
        end
    end

    always_comb begin
        ld_rvalid_d = ld_own && !ld_we;
        ld_rdata_d  = ld_rvalid_d ? Data_out : ld_rdata_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_NORMAL;
            starve_q    <= 4'd0;
            ld_rvalid_q <= 1'b0;
            ld_rdata_q  <= 32'd0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            ld_rvalid_q <= ld_rvalid_d;
            ld_rdata_q  <= ld_rdata_d;
        end
    end

    assign ld_rvalid = ld_rvalid_q;
    assign ld_rdata  = ld_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter with a behavioural arbitration model
module tb_dmem_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRd_MEM, MemWr_MEM;
    logic [5:0]  Addr_MEM;
    logic [31:0] Din_MEM;
    logic [31:0] Dout_MEM;
    logic        Stall_MEM;
    logic        ld_valid, ld_we;
    logic [5:0]  ld_addr;
    logic [31:0] ld_wdata;
    logic        ld_ready, ld_rvalid;
    logic [31:0] ld_rdata;
    logic        MemRd, MemWr_final;
    logic [5:0]  Address;
    logic [31:0] Data_in, Data_out;

    logic [31:0] dmem [64];
    logic        mem_clear;

    int errors = 0;
    int checks = 0;

    // behavioural model state
    logic [31:0] ref_mem [64];
    bit          m_force;
    int          m_wait;
    logic        exp_rvalid;
    logic [31:0] exp_rdata;
    logic        e_pipe, e_ld, e_stall, e_memrd, e_memwr;
    logic [5:0]  e_addr;
    logic [31:0] e_din, e_dout;

    always #5 clk = ~clk;

    dmem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset),
        .MemRd_MEM(MemRd_MEM), .MemWr_MEM(MemWr_MEM), .Addr_MEM(Addr_MEM), .Din_MEM(Din_MEM),
        .Dout_MEM(Dout_MEM), .Stall_MEM(Stall_MEM),
        .ld_valid(ld_valid), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_ready(ld_ready), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
        .MemRd(MemRd), .MemWr_final(MemWr_final), .Address(Address), .Data_in(Data_in),
        .Data_out(Data_out)
    );

    assign Data_out = MemRd ? dmem[Address] : 32'h0;

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 64; i++) dmem[i] <= 32'h0;
        end else if (MemWr_final) begin
            dmem[Address] <= Data_in;
        end
    end

    task automatic predict();
        logic preq;
        preq = MemRd_MEM | MemWr_MEM;
        e_pipe = 1'b0;
        e_ld   = 1'b0;
        if (!reset) begin
            if (m_force) begin
                e_ld   = ld_valid;
                e_pipe = !ld_valid && preq;
            end else begin
                e_pipe = preq;
                e_ld   = !preq && ld_valid;
            end
        end
        e_stall = !reset && m_force && ld_valid && preq;
        e_memrd = e_pipe ? MemRd_MEM : (e_ld ? !ld_we : 1'b0);
        e_memwr = e_pipe ? MemWr_MEM : (e_ld ? ld_we : 1'b0);
        e_addr  = e_pipe ? Addr_MEM : (e_ld ? ld_addr : 6'd0);
        e_din   = e_pipe ? Din_MEM : (e_ld ? ld_wdata : 32'd0);
        e_dout  = (e_pipe && MemRd_MEM) ? ref_mem[Addr_MEM] : 32'd0;
    endtask

    task automatic apply_model();
        if (reset) begin
            m_force = 0; m_wait = 0; exp_rvalid = 1'b0; exp_rdata = 32'd0;
        end else begin
            exp_rvalid = e_ld && !ld_we;
            if (exp_rvalid) exp_rdata = ref_mem[ld_addr];
            if (e_pipe && MemWr_MEM) ref_mem[Addr_MEM] = Din_MEM;
            if (e_ld && ld_we) ref_mem[ld_addr] = ld_wdata;
            if (m_force) begin
                m_force = 0; m_wait = 0;
            end else if (ld_valid && !e_ld) begin
                m_wait++;
                if (m_wait == LIMIT) begin m_force = 1; m_wait = 0; end
            end else begin
                m_wait = 0;
            end
        end
    endtask

    task automatic settle();
        #1;
        predict();
    endtask

    task automatic advance();
        predict();
        @(posedge clk);
        apply_model();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        MemRd_MEM = 0; MemWr_MEM = 0; Addr_MEM = 0; Din_MEM = 0;
        ld_valid = 0; ld_we = 0; ld_addr = 0; ld_wdata = 0;
    endtask

    task automatic test_reset();
        MemWr_MEM = 1; Addr_MEM = 6'd3; Din_MEM = 32'h1; ld_valid = 1; ld_we = 0; ld_addr = 6'd4;
        settle();
        checks++; if ({MemRd, MemWr_final} !== 2'b00) begin errors++; $display("FAIL rst_enables got=%b exp=00", {MemRd, MemWr_final}); end
        checks++; if ({ld_ready, Stall_MEM} !== 2'b00) begin errors++; $display("FAIL rst_ready_stall got=%b exp=00", {ld_ready, Stall_MEM}); end
        checks++; if (Dout_MEM !== 32'h0) begin errors++; $display("FAIL rst_dout got=%h exp=0", Dout_MEM); end
        advance();
        checks++; if (ld_rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid got=%b exp=0", ld_rvalid); end
        checks++; if (ld_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got=%h exp=0", ld_rdata); end
        reset = 0; mem_clear = 0; idle_inputs();
    endtask

    task automatic test_pipeline();
        MemWr_MEM = 1; Addr_MEM = 6'd10; Din_MEM = 32'hAAAA5555;
        settle();
        checks++; if ({MemWr_final, Address, Data_in} !== {1'b1, 6'd10, 32'hAAAA5555}) begin errors++;
            $display("FAIL pipe_write got=%b/%0d/%h exp=1/10/aaaa5555", MemWr_final, Address, Data_in); end
        advance();
        MemWr_MEM = 0; MemRd_MEM = 1;
        settle();
        checks++; if (Dout_MEM !== 32'hAAAA5555) begin errors++; $display("FAIL pipe_read got=%h exp=aaaa5555", Dout_MEM); end
        checks++; if ({ld_ready, Stall_MEM} !== 2'b00) begin errors++; $display("FAIL pipe_ready_stall got=%b exp=00", {ld_ready, Stall_MEM}); end
        advance();
        idle_inputs();
    endtask

    task automatic test_loader_read();
        ld_valid = 1; ld_we = 0; ld_addr = 6'd10;
        settle();
        checks++; if ({ld_ready, MemRd, MemWr_final, Dout_MEM} !== {3'b110, 32'h0}) begin errors++;
            $display("FAIL ld_read_accept got=%b%b%b/%h exp=110/0", ld_ready, MemRd, MemWr_final, Dout_MEM); end
        advance();
        ld_valid = 0;
        checks++; if ({ld_rvalid, ld_rdata} !== {1'b1, 32'hAAAA5555}) begin errors++;
            $display("FAIL ld_read_data got=%b/%h exp=1/aaaa5555", ld_rvalid, ld_rdata); end
        settle();
        advance();
        checks++; if ({ld_rvalid, ld_rdata} !== {1'b0, 32'hAAAA5555}) begin errors++;
            $display("FAIL ld_read_hold got=%b/%h exp=0/aaaa5555", ld_rvalid, ld_rdata); end
    endtask

    task automatic test_contention();
        MemRd_MEM = 1; Addr_MEM = 6'd3;
        ld_valid = 1; ld_we = 1; ld_addr = 6'd20; ld_wdata = 32'h12345678;
        for (int c = 1; c <= 6; c++) begin
            logic acc;
            settle();
            acc = (c == LIMIT + 1);
            checks++; if ({ld_ready, Stall_MEM} !== {acc, acc}) begin errors++;
                $display("FAIL contention_c%0d got=%b%b exp=%b%b", c, ld_ready, Stall_MEM, acc, acc); end
            advance();
            if (acc) ld_valid = 0;
        end
        Addr_MEM = 6'd20;
        settle();
        checks++; if (Dout_MEM !== 32'h12345678) begin errors++; $display("FAIL contention_readback got=%h exp=12345678", Dout_MEM); end
        advance();
        idle_inputs();
    endtask

    task automatic test_drop_in_force();
        MemWr_MEM = 1; Addr_MEM = 6'd5; Din_MEM = 32'h00000505;
        ld_valid = 1; ld_we = 0; ld_addr = 6'd7;
        for (int c = 0; c < LIMIT; c++) begin settle(); advance(); end
        ld_valid = 0;
        settle();
        checks++; if ({Stall_MEM, MemWr_final, Address} !== {2'b01, 6'd5}) begin errors++;
            $display("FAIL drop_force got=%b%b/%0d exp=01/5", Stall_MEM, MemWr_final, Address); end
        advance();
        ld_valid = 1;
        for (int c = 1; c <= LIMIT + 1; c++) begin
            settle();
            checks++; if (ld_ready !== (c == LIMIT + 1)) begin errors++;
                $display("FAIL drop_recount_c%0d got=%b exp=%b", c, ld_ready, (c == LIMIT + 1)); end
            advance();
        end
        ld_valid = 0;
        checks++; if (ld_rvalid !== 1'b1) begin errors++; $display("FAIL drop_rvalid got=%b exp=1", ld_rvalid); end
        idle_inputs();
    endtask

    task automatic test_same_addr();
        MemWr_MEM = 1; Addr_MEM = 6'd10; Din_MEM = 32'h11111111;
        ld_valid = 1; ld_we = 1; ld_addr = 6'd10; ld_wdata = 32'h22222222;
        settle();
        checks++; if ({ld_ready, MemWr_final, Data_in} !== {2'b01, 32'h11111111}) begin errors++;
            $display("FAIL same_addr_pipe got=%b%b/%h exp=01/11111111", ld_ready, MemWr_final, Data_in); end
        advance();
        MemWr_MEM = 0;
        settle();
        checks++; if ({ld_ready, MemWr_final, Data_in} !== {2'b11, 32'h22222222}) begin errors++;
            $display("FAIL same_addr_ld got=%b%b/%h exp=11/22222222", ld_ready, MemWr_final, Data_in); end
        advance();
        ld_valid = 0; MemRd_MEM = 1;
        settle();
        checks++; if (Dout_MEM !== 32'h22222222) begin errors++; $display("FAIL same_addr_final got=%h exp=22222222", Dout_MEM); end
        advance();
        idle_inputs();
    endtask

    task automatic test_reset_in_force();
        MemRd_MEM = 1; Addr_MEM = 6'd1;
        ld_valid = 1; ld_we = 0; ld_addr = 6'd10;
        for (int c = 0; c < LIMIT; c++) begin settle(); advance(); end
        reset = 1;
        settle();
        checks++; if ({MemRd, MemWr_final, Stall_MEM, ld_ready} !== 4'b0000) begin errors++;
            $display("FAIL rst_force_comb got=%b exp=0000", {MemRd, MemWr_final, Stall_MEM, ld_ready}); end
        advance();
        checks++; if ({ld_rvalid, ld_rdata} !== 33'h0) begin errors++;
            $display("FAIL rst_force_reg got=%b/%h exp=0/0", ld_rvalid, ld_rdata); end
        reset = 0; idle_inputs();
        settle(); advance();
    endtask

    task automatic test_random();
        logic acc;
        int   op;
        acc = 1'b0;
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 99) == 0);
            op = $urandom_range(0, 3);
            MemRd_MEM = (op == 1);
            MemWr_MEM = (op >= 2);
            Addr_MEM  = 6'($urandom_range(0, 7));
            Din_MEM   = $urandom;
            if (!ld_valid || acc) begin
                ld_valid = 1'($urandom_range(0, 1));
                ld_we    = 1'($urandom_range(0, 1));
                ld_addr  = 6'($urandom_range(0, 7));
                ld_wdata = $urandom;
            end else if ($urandom_range(0, 9) == 0) begin
                ld_valid = 0;
            end
            settle();
            acc = e_ld;
            checks++;
            if ({ld_ready, Stall_MEM, MemRd, MemWr_final, Address, Data_in, Dout_MEM} !==
                {e_ld, e_stall, e_memrd, e_memwr, e_addr, e_din, e_dout}) begin
                errors++;
                $display("FAIL rand_comb_%0d got=%b%b%b%b/%0d/%h/%h exp=%b%b%b%b/%0d/%h/%h", i,
                         ld_ready, Stall_MEM, MemRd, MemWr_final, Address, Data_in, Dout_MEM,
                         e_ld, e_stall, e_memrd, e_memwr, e_addr, e_din, e_dout);
            end
            advance();
            checks++;
            if ({ld_rvalid, ld_rdata} !== {exp_rvalid, exp_rdata}) begin
                errors++;
                $display("FAIL rand_reg_%0d got=%b/%h exp=%b/%h", i, ld_rvalid, ld_rdata, exp_rvalid, exp_rdata);
            end
        end
        reset = 0; idle_inputs();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;
        m_force = 0; m_wait = 0; exp_rvalid = 1'b0; exp_rdata = 32'h0;
        idle_inputs();
        reset = 1; mem_clear = 1;
        @(negedge clk);
        test_reset();
        test_pipeline();
        test_loader_read();
        test_contention();
        test_drop_in_force();
        test_same_addr();
        test_reset_in_force();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
